// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte sources.
// Grants one byte, pulses tx_start, then waits for tx_done_tick or a watchdog abort.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DBIT        = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DBIT-1:0] din_flat,
  output logic [N_REQ-1:0]      gnt,
  output logic                  tx_start,
  output logic [DBIT-1:0]       tx_din,
  input  logic                  tx_done_tick,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [1:0]            state_dbg
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] PTR_RST   = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [DBIT-1:0]   tx_din_q, tx_din_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;

  logic              win_valid;
  logic [PW-1:0]     win_idx;
  logic              timeout_hit;

  // Search starts just after the last served source so priority rotates.
  always_comb begin
    int cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(ptr_q) + i) % N_REQ;
      if (!win_valid && req[PW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // Completion wins over the watchdog when both land on the same cycle.
  assign timeout_hit = (state_q == S_WAIT) && !tx_done_tick && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_RST;
      owner_q       <= '0;
      wdog_q        <= '0;
      tx_din_q      <= '0;
      gnt_q         <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      wdog_q        <= wdog_d;
      tx_din_q      <= tx_din_d;
      gnt_q         <= gnt_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    wdog_d   = wdog_q;
    tx_din_d = tx_din_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          tx_din_d = din_flat[int'(win_idx)*DBIT +: DBIT];
          owner_d  = win_idx;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (tx_done_tick || timeout_hit) begin
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d         = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = timeout_hit;
    busy_d        = (state_d != S_IDLE);
    if (state_q == S_IDLE && win_valid) begin
      gnt_d = N_REQ'(1) << win_idx;
    end
    if (state_q == S_LAUNCH) begin
      tx_start_d = 1'b1;
    end
  end

  assign gnt         = gnt_q;
  assign tx_start    = tx_start_q;
  assign tx_din      = tx_din_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, launch timing, watchdog,
// asynchronous reset mid-frame and stray done ticks.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int DBIT  = 8;
  localparam int TOUT  = 50;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ*DBIT-1:0] din_flat = '0;
  logic [N_REQ-1:0]      gnt;
  logic                  tx_start;
  logic [DBIT-1:0]       tx_din;
  logic                  tx_done_tick = 1'b0;
  logic                  busy;
  logic                  timeout_err;
  logic [1:0]            state_dbg;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DBIT(DBIT), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .din_flat(din_flat), .gnt(gnt),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Called #1 after an edge with the arbiter in IDLE and req already set.
  task automatic run_frame(input string tag, input logic [3:0] exp_gnt,
                           input logic [7:0] exp_din, input logic drop,
                           input logic [3:0] add_mask, input int delay);
    tick();
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".din"}, 32'(tx_din), 32'(exp_din));
    if (drop) req = req & ~exp_gnt;
    tick();
    chk({tag, ".start"}, 32'(tx_start), 32'd1);
    chk({tag, ".gnt_off"}, 32'(gnt), 32'd0);
    req = req | add_mask;
    repeat (delay - 1) tick();
    chk({tag, ".busy_hi"}, 32'(busy), 32'd1);
    chk({tag, ".din_hold"}, 32'(tx_din), 32'(exp_din));
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk({tag, ".busy_lo"}, 32'(busy), 32'd0);
    chk({tag, ".idle"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.start", 32'(tx_start), 32'd0);
    chk("rst.din", 32'(tx_din), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.terr", 32'(timeout_err), 32'd0);
    chk("rst.state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single requester, done 10 cycles after start
    din_flat = {8'h00, 8'hA5, 8'h00, 8'h00};
    req = 4'b0100;
    run_frame("t1", 4'b0100, 8'hA5, 1'b1, 4'b0000, 10);
    tick();
    chk("t1.no_regrant", 32'(gnt), 32'd0);

    // All four holding: strict rotation from source 0
    do_reset();
    din_flat = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    run_frame("t2a", 4'b0001, 8'h10, 1'b0, 4'b0000, 6);
    run_frame("t2b", 4'b0010, 8'h11, 1'b0, 4'b0000, 6);
    run_frame("t2c", 4'b0100, 8'h12, 1'b0, 4'b0000, 6);
    run_frame("t2d", 4'b1000, 8'h13, 1'b0, 4'b0000, 6);
    run_frame("t2e", 4'b0001, 8'h10, 1'b0, 4'b0000, 6);
    req = 4'b0000;

    // Source 0 continuous, source 2 joins mid-frame
    do_reset();
    din_flat = {8'h33, 8'h22, 8'h11, 8'h44};
    req = 4'b0001;
    run_frame("t3a", 4'b0001, 8'h44, 1'b0, 4'b0100, 5);
    run_frame("t3b", 4'b0100, 8'h22, 1'b0, 4'b0000, 5);
    run_frame("t3c", 4'b0001, 8'h44, 1'b0, 4'b0000, 5);
    run_frame("t3d", 4'b0100, 8'h22, 1'b0, 4'b0000, 5);
    req = 4'b0000;

    // Watchdog abort: TX never answers
    do_reset();
    din_flat = {8'hD3, 8'h00, 8'h7E, 8'h00};
    req = 4'b0010;
    tick();
    chk("t4.gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    tick();
    chk("t4.start", 32'(tx_start), 32'd1);
    req = 4'b1001;
    repeat (TOUT - 1) tick();
    chk("t4.terr_early", 32'(timeout_err), 32'd0);
    chk("t4.busy_wait", 32'(busy), 32'd1);
    tick();
    chk("t4.terr", 32'(timeout_err), 32'd1);
    chk("t4.busy_lo", 32'(busy), 32'd0);
    chk("t4.idle", 32'(state_dbg), 32'd0);
    tick();
    chk("t4.terr_pulse", 32'(timeout_err), 32'd0);
    chk("t4.next_gnt", 32'(gnt), 32'b1000);
    chk("t4.next_din", 32'(tx_din), 32'hD3);
    req = 4'b0000;

    // Asynchronous reset in the middle of a frame
    do_reset();
    din_flat = {8'h00, 8'h5C, 8'h00, 8'h00};
    req = 4'b0100;
    tick();
    chk("t5.gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    tick();
    chk("t5.start", 32'(tx_start), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5.start_async", 32'(tx_start), 32'd0);
    chk("t5.busy_async", 32'(busy), 32'd0);
    chk("t5.state_async", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #2;
    din_flat = {8'h9B, 8'h00, 8'h61, 8'h00};
    req = 4'b1010;
    reset = 1'b0;
    run_frame("t5r", 4'b0010, 8'h61, 1'b1, 4'b0000, 4);
    chk("t5.terr", 32'(timeout_err), 32'd0);
    req = 4'b0000;

    // Done tick while idle with no requests, then while in LAUNCH
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("t6.gnt", 32'(gnt), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.state", 32'(state_dbg), 32'd0);
    tick();
    chk("t6.start", 32'(tx_start), 32'd0);
    din_flat = {8'hE4, 8'hC3, 8'hB2, 8'hA1};
    req = 4'b1111;
    tick();
    chk("t6.ptr_gnt", 32'(gnt), 32'b0100);
    chk("t6.ptr_din", 32'(tx_din), 32'hC3);
    req = 4'b0000;
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("t6.launch_start", 32'(tx_start), 32'd1);
    chk("t6.launch_wait", 32'(state_dbg), 32'd2);
    chk("t6.launch_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("t6.end_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
